// File: rtl/slow_clk_pkg.sv
// Shared definitions for the slow clock monitor.
//   state_t      : monitor state (IDLE = no reference edge yet, MEASURE)
//   DEF_CNT_W    : default width of the cycle counters
//   DEF_TIMEOUT  : default loss timeout in fast-clock cycles
package slow_clk_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned DEF_CNT_W   = 28;
  localparam logic [27:0] DEF_TIMEOUT = 28'd100000000;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer bringing an asynchronous level into the
// clock_in domain. Both flops clear to 0 on a synchronous reset.
//   clock_in : destination clock
//   reset    : synchronous, active-high
//   din      : asynchronous input
//   dout     : synchronized output (second flop)
module sync_2ff (
  input  logic clock_in,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic sync1;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1 <= 1'b0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      dout  <= sync1;
    end
  end

endmodule

// File: rtl/slow_clock_monitor.sv
// Samples a slow (divided) clock as data in the clock_in domain, measures
// its rise-to-rise period and high time in clock_in cycles, and flags loss
// of the slow clock after TIMEOUT cycles without a rising edge.
//
// Optional feature: define SLOW_CLOCK_MONITOR_DUTY_EN to implement the
// high-time counter. Without it, high_time is tied to 0.
//
// Ports:
//   clock_in   : fast system clock, sole clock of the block
//   reset      : synchronous, active-high
//   clock_sig  : slow clock under test, asynchronous to clock_in
//   rise_tick  : one-cycle pulse per detected rising edge of clock_sig
//   meas_valid : one-cycle pulse, period/high_time updated this cycle
//   period     : last complete rise-to-rise interval (clock_in cycles)
//   high_time  : cycles the synchronized signal was high in that interval
//   clock_lost : level, slow clock considered stopped
module slow_clock_monitor
  import slow_clk_pkg::*;
#(
  parameter int unsigned       CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  TIMEOUT = CNT_W'(DEF_TIMEOUT)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             clock_sig,
  output logic             rise_tick,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             clock_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - CNT_W'(1);

  logic             sync2;
  logic             s_prev;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt_meas;
  state_t           state;

  sync_2ff u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (clock_sig),
    .dout     (sync2)
  );

  // Edge detect on the synchronized signal
  always_ff @(posedge clock_in) begin
    if (reset) s_prev <= 1'b0;
    else       s_prev <= sync2;
  end

  assign rise = sync2 & ~s_prev;

  // Cycles since the last rise; saturates so a stopped clock never wraps
  // back into a false timeout window.
  always_ff @(posedge clock_in) begin
    if (reset)                cnt <= '0;
    else if (rise)            cnt <= '0;
    else if (cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);
  end

`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  // Loads 1 on a rise because the rise cycle itself has sync2 high.
  always_ff @(posedge clock_in) begin
    if (reset)                         hcnt <= '0;
    else if (rise)                     hcnt <= CNT_W'(1);
    else if (sync2 && hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
  end

  assign hcnt_meas = hcnt;
`else
  assign hcnt_meas = '0;
`endif

  // Monitor FSM with registered outputs. A rise on the timeout cycle takes
  // priority, so a period of exactly TIMEOUT is measured, not flagged lost.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= IDLE;
      rise_tick  <= 1'b0;
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      clock_lost <= 1'b0;
    end else begin
      rise_tick  <= rise;
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= MEASURE;
            clock_lost <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= cnt + CNT_W'(1);
            high_time  <= hcnt_meas;
            meas_valid <= 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            clock_lost <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor (CNT_W=8, TIMEOUT=100). A reference model
// keeps the per-edge history of sampled clock_sig and derives expected
// outputs from it: rises appear two edges after sampling, periods are edge
// distances between rises, high time is the count of high samples in the
// interval.
module tb_slow_clock_monitor;

  localparam int unsigned CNT_W      = 8;
  localparam int          TO         = 100;
  localparam logic [7:0]  TB_TIMEOUT = 8'd100;
`ifdef SLOW_CLOCK_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clock_in  = 1'b0;
  logic             reset     = 1'b1;
  logic             clock_sig = 1'b0;
  logic             rise_tick;
  logic             meas_valid;
  logic             clock_lost;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rt_cyc = 0;

  always #5 clock_in = ~clock_in;

  slow_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .clock_sig  (clock_sig),
    .rise_tick  (rise_tick),
    .meas_valid (meas_valid),
    .period     (period),
    .high_time  (high_time),
    .clock_lost (clock_lost)
  );

  // ---------------- reference model ----------------
  bit               hist [0:65535];
  int               n = 0;
  int               last = 0;
  bit               measuring = 1'b0;
  logic             e_rt = 1'b0, e_mv = 1'b0, e_lost = 1'b0;
  logic [CNT_W-1:0] e_per = '0, e_ht = '0;

  always @(posedge clock_in) begin
    int  h;
    bit  r;
    n++;
    if (reset) begin
      hist[n] = 1'b0;
      hist[n-1] = 1'b0;
      e_rt = 1'b0; e_mv = 1'b0; e_lost = 1'b0; e_per = '0; e_ht = '0;
      measuring = 1'b0;
    end else begin
      hist[n] = clock_sig;
      r = (n >= 3) && hist[n-2] && !hist[n-3];
      e_rt = r;
      e_mv = 1'b0;
      if (r) begin
        if (measuring) begin
          e_mv = 1'b1;
          e_per = CNT_W'(n - last);
          h = 0;
          for (int k = last - 2; k <= n - 3; k++) h += int'(hist[k]);
          e_ht = DUTY ? CNT_W'(h) : '0;
        end
        measuring = 1'b1;
        e_lost = 1'b0;
        last = n;
      end else if (measuring && (n - last) == TO) begin
        e_lost = 1'b1;
        measuring = 1'b0;
      end
    end
  end

  function automatic logic [2*CNT_W+2:0] dut_v();
    return {rise_tick, meas_valid, clock_lost, period, high_time};
  endfunction

  function automatic logic [2*CNT_W+2:0] exp_v();
    return {e_rt, e_mv, e_lost, e_per, e_ht};
  endfunction

  // Drive clock_sig for one cycle; return on the following falling edge.
  task automatic tick(input logic cs);
    clock_sig = cs;
    @(negedge clock_in);
    cyc++;
    if (rise_tick === 1'b1) last_rt_cyc = cyc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick(1'b0);
    tests++;
    if (dut_v() !== '0) begin
      fails++;
      $display("FAIL reset_state got %h want 0", dut_v());
    end
    reset = 1'b0;
    repeat (4) begin
      tick(1'b0);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
    end
  endtask

  task automatic test_period20();
    int good = 0;
    for (int c = 0; c < 120; c++) begin
      tick((c % 20) < 5);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL p20_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (meas_valid === 1'b1 && period === 8'd20 && high_time === (DUTY ? 8'd5 : 8'd0)) good++;
    end
    tests++;
    if (good != 5) begin
      fails++;
      $display("FAIL p20_meas_count got %0d want 5", good);
    end
  endtask

  task automatic test_duty50();
    int good = 0;
    for (int c = 0; c < 200; c++) begin
      tick((c % 40) < 20);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL d50_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      // high sampled on edge of iteration c, rise_tick registered two edges later
      if ((c % 40) == 2) begin
        tests++;
        if (rise_tick !== 1'b1) begin
          fails++;
          $display("FAIL d50_latency cyc=%0d got rise_tick=%b want 1", cyc, rise_tick);
        end
      end
      if (meas_valid === 1'b1 && period === 8'd40 && high_time === (DUTY ? 8'd20 : 8'd0)) good++;
    end
    tests++;
    if (good != 4) begin
      fails++;
      $display("FAIL d50_meas_count got %0d want 4", good);
    end
  endtask

  task automatic test_loss();
    int  waited = 0;
    bit  seen = 1'b0;
    int  first_ok = 0;
    int  mv_cnt = 0;
    bit  first_rt = 1'b1;
    while (!seen && waited < 300) begin
      tick(1'b0);
      waited++;
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL loss_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (clock_lost === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || (cyc - last_rt_cyc) != TO) begin
      fails++;
      $display("FAIL loss_delay got %0d cycles (seen=%0d) want %0d", cyc - last_rt_cyc, seen, TO);
    end
    tests++;
    if (period !== 8'd40) begin
      fails++;
      $display("FAIL loss_period_hold got %0d want 40", period);
    end
    for (int c = 0; c < 120; c++) begin
      tick((c % 40) < 20);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL resume_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (rise_tick === 1'b1 && first_rt) begin
        first_rt = 1'b0;
        if (meas_valid === 1'b0 && clock_lost === 1'b0) first_ok = 1;
      end
      if (meas_valid === 1'b1 && period === 8'd40) mv_cnt++;
    end
    tests++;
    if (first_ok != 1) begin
      fails++;
      $display("FAIL resume_first_rise got ok=%0d want 1", first_ok);
    end
    tests++;
    if (mv_cnt != 2) begin
      fails++;
      $display("FAIL resume_meas_count got %0d want 2", mv_cnt);
    end
  endtask

  task automatic test_period100();
    int good = 0;
    int lost_cycles = 0;
    for (int c = 0; c < 400; c++) begin
      tick((c % 100) < 30);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL p100_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (clock_lost !== 1'b0) lost_cycles++;
      if (meas_valid === 1'b1 && period === 8'd100) good++;
    end
    tests++;
    if (good != 3 || lost_cycles != 0) begin
      fails++;
      $display("FAIL p100_boundary got meas=%0d lost_cycles=%0d want meas=3 lost_cycles=0", good, lost_cycles);
    end
  endtask

  task automatic test_reset_mid();
    bit first_rt = 1'b1;
    int first_ok = 0;
    int good = 0;
    for (int c = 0; c < 120; c++) begin
      reset = (c == 45);
      tick((c % 30) < 10);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL rmid_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (c == 45) begin
        tests++;
        if (dut_v() !== '0) begin
          fails++;
          $display("FAIL rmid_clear got %h want 0", dut_v());
        end
      end
      if (c > 45) begin
        if (rise_tick === 1'b1 && first_rt) begin
          first_rt = 1'b0;
          if (meas_valid === 1'b0) first_ok = 1;
        end
        if (meas_valid === 1'b1 && period === 8'd30) good++;
      end
    end
    reset = 1'b0;
    tests++;
    if (first_ok != 1 || good != 1) begin
      fails++;
      $display("FAIL rmid_after got first_ok=%0d meas=%0d want 1 and 1", first_ok, good);
    end
  endtask

  task automatic test_glitch();
    int rts = 0;
    for (int c = 0; c < 170; c++) begin
      tick(c == 20);
      tests++;
      if (dut_v() !== exp_v()) begin
        fails++;
        $display("FAIL glitch_model cyc=%0d got %h want %h", cyc, dut_v(), exp_v());
      end
      if (rise_tick === 1'b1 && c >= 20) rts++;
    end
    tests++;
    if (rts > 1) begin
      fails++;
      $display("FAIL glitch_ticks got %0d want <=1", rts);
    end
  endtask

  task automatic test_random();
    int per, hi, len;
    int done = 0;
    while (done < 3000) begin
      per = int'($urandom_range(3, 130));
      hi  = int'($urandom_range(1, per - 1));
      len = per * int'($urandom_range(1, 4));
      for (int c = 0; c < len; c++) begin
        reset = ($urandom_range(0, 999) == 0);
        tick((c % per) < hi);
        tests++;
        if (dut_v() !== exp_v()) begin
          fails++;
          $display("FAIL rand_model cyc=%0d per=%0d hi=%0d got %h want %h", cyc, per, hi, dut_v(), exp_v());
        end
      end
      done += len;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period20();
    test_duty50();
    test_loss();
    test_period100();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
